// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store port and the debug/loader port.
// Round-robin with a debug burst lock, plus a starvation guard bounding core stall time.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

  port_e         last;
  logic [WW-1:0] wait_cnt;
  logic          rd_c;
  logic          rd_d;
  logic          grant_core;
  logic          grant_dbg;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is asserted.
  always_comb begin
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    if (rst_n) begin
      if (core_req && !dbg_req) begin
        grant_core = 1'b1;
      end else if (dbg_req && !core_req) begin
        grant_dbg = 1'b1;
      end else if (core_req && dbg_req) begin
        if (wait_cnt == WAIT_MAX) begin
          grant_core = 1'b1;
        end else if (dbg_lock && (last == PORT_DBG)) begin
          grant_dbg = 1'b1;
        end else if (last == PORT_DBG) begin
          grant_core = 1'b1;
        end else begin
          grant_dbg = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_en    = grant_core | grant_dbg;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_core) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (grant_dbg) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign core_gnt    = grant_core;
  assign dbg_gnt     = grant_dbg;
  assign core_rvalid = rd_c;
  assign dbg_rvalid  = rd_d;
  assign core_rdata  = mem_rdata;
  assign dbg_rdata   = mem_rdata;

  // last starts at debug so the core wins the first tie out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= PORT_DBG;
      wait_cnt <= '0;
      rd_c     <= 1'b0;
      rd_d     <= 1'b0;
    end else begin
      if (grant_core) begin
        last <= PORT_CORE;
      end else if (grant_dbg) begin
        last <= PORT_DBG;
      end
      if (core_req && !grant_core) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
      rd_c <= grant_core & ~core_we;
      rd_d <= grant_dbg & ~dbg_we;
    end
  end

endmodule
